// File: rtl/fpga_cg_pkg.sv
// Shared types and default sizing for the clock-gate enable controller.
package fpga_cg_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        GATED     = 2'd2,
        WAKE      = 2'd3
    } cg_state_t;

    localparam int CG_IDLE_CNT_W  = 8;
    localparam int CG_WAKE_SETTLE = 2;
    localparam int CG_GATE_CNT_W  = 16;

endpackage

// File: rtl/fpga_cg_sat_cnt.sv
// Saturating up-counter; a synchronous clear beats a same-cycle increment.
module fpga_cg_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fpga_cg_en_ctrl.sv
// Drives the ICG enable: gates after a run of idle cycles, wakes with a settle
// delay and a one-cycle acknowledge, and counts gating events.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | clock running, waiting for the first qualifying idle cycle
// IDLE_WAIT | counting consecutive idle cycles up to the latched threshold
// GATED     | clock gated, waiting for any break condition
// WAKE      | enable restored, settling before RUN and wake_ack
module fpga_cg_en_ctrl
    import fpga_cg_pkg::*;
#(
    parameter int IDLE_CNT_W  = CG_IDLE_CNT_W,
    parameter int WAKE_SETTLE = CG_WAKE_SETTLE,
    parameter int GATE_CNT_W  = CG_GATE_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  cg_req,
    input  logic                  activity,
    input  logic                  dbg_force_on,
    input  logic [IDLE_CNT_W-1:0] idle_thresh,
    input  logic                  gate_cnt_clr,
    output logic                  cg_en,
    output logic                  gated_status,
    output logic                  wake_ack,
    output logic [GATE_CNT_W-1:0] gate_cnt
);

    localparam int SETTLE_W = $clog2(WAKE_SETTLE + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(WAKE_SETTLE - 1);

    generate
        if (WAKE_SETTLE < 1) begin : g_bad_settle
            $error("fpga_cg_en_ctrl: WAKE_SETTLE must be at least 1");
        end
    endgenerate

    cg_state_t             state, state_nxt;
    logic [IDLE_CNT_W-1:0] idle_cnt, idle_nxt;
    logic [IDLE_CNT_W-1:0] thr, thr_nxt;
    logic [SETTLE_W-1:0]   settle_cnt, settle_nxt;
    logic                  wake_pend;
    logic                  qual;

    assign qual = cg_req && !activity && !dbg_force_on;

    always_comb begin
        state_nxt  = state;
        idle_nxt   = idle_cnt;
        thr_nxt    = thr;
        settle_nxt = settle_cnt;
        case (state)
            RUN: begin
                if (qual) begin
                    state_nxt = IDLE_WAIT;
                    idle_nxt  = '0;
                    thr_nxt   = (idle_thresh == '0) ? IDLE_CNT_W'(1) : idle_thresh;
                end
            end
            IDLE_WAIT: begin
                // a break always wins over reaching the threshold
                if (!qual) begin
                    state_nxt = RUN;
                    idle_nxt  = '0;
                end else if (idle_cnt == thr - IDLE_CNT_W'(1)) begin
                    state_nxt = GATED;
                    idle_nxt  = '0;
                end else begin
                    idle_nxt = idle_cnt + IDLE_CNT_W'(1);
                end
            end
            GATED: begin
                if (!qual) begin
                    state_nxt  = WAKE;
                    settle_nxt = '0;
                end
            end
            WAKE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt  = RUN;
                    settle_nxt = '0;
                end else begin
                    settle_nxt = settle_cnt + SETTLE_W'(1);
                end
            end
            default: begin
                state_nxt  = RUN;
                idle_nxt   = '0;
                settle_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= RUN;
            idle_cnt   <= '0;
            thr        <= IDLE_CNT_W'(1);
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            idle_cnt   <= idle_nxt;
            thr        <= thr_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    // Outputs are decoded from the registered state one cycle later, so cg_en
    // is a plain flop output and cannot glitch.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cg_en        <= 1'b1;
            gated_status <= 1'b0;
            wake_pend    <= 1'b0;
            wake_ack     <= 1'b0;
        end else begin
            cg_en        <= (state != GATED);
            gated_status <= (state == GATED);
            wake_pend    <= (state == WAKE) && (state_nxt == RUN);
            wake_ack     <= wake_pend;
        end
    end

    fpga_cg_sat_cnt #(
        .W (GATE_CNT_W)
    ) u_gate_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (gate_cnt_clr),
        .inc   ((state == GATED) && !gated_status),
        .cnt   (gate_cnt)
    );

endmodule

// File: tb/tb_fpga_cg_en_ctrl.sv
// Randomized scoreboard bench: episodes are planned as event times, expected
// per-edge outputs are queued, and a negedge monitor compares them.
module tb_fpga_cg_en_ctrl;

    localparam int IW = 8;
    localparam int S  = 2;
    localparam int CW = 2;
    localparam int MAXL = 128;

    logic          clk = 1'b0;
    logic          rst_b = 1'b1;
    logic          cg_req = 1'b0;
    logic          activity = 1'b0;
    logic          dbg_force_on = 1'b0;
    logic [IW-1:0] idle_thresh = '0;
    logic          gate_cnt_clr = 1'b0;
    logic          cg_en;
    logic          gated_status;
    logic          wake_ack;
    logic [CW-1:0] gate_cnt;

    fpga_cg_en_ctrl #(
        .IDLE_CNT_W  (IW),
        .WAKE_SETTLE (S),
        .GATE_CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .cg_req       (cg_req),
        .activity     (activity),
        .dbg_force_on (dbg_force_on),
        .idle_thresh  (idle_thresh),
        .gate_cnt_clr (gate_cnt_clr),
        .cg_en        (cg_en),
        .gated_status (gated_status),
        .wake_ack     (wake_ack),
        .gate_cnt     (gate_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       en;
        logic       gs;
        logic       wa;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   model_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s @edge %0d: got %0h expected %0h", nm, cyc, act, req);
    endtask

    // Monitor: every queued expectation is compared at the negedge of its edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                x = exp_q.pop_front();
                if (x.cyc < cyc) begin
                    chk("stale_expectation", cyc, x.cyc);
                end else begin
                    chk("cg_en", cg_en, x.en);
                    chk("gated_status", gated_status, x.gs);
                    chk("wake_ack", wake_ack, x.wa);
                    chk("gate_cnt", gate_cnt, x.cnt);
                end
            end
        end
    end

    logic       p_req[MAXL];
    logic       p_act[MAXL];
    logic       p_dbg[MAXL];
    logic       p_clr[MAXL];
    logic [7:0] p_thr[MAXL];

    function automatic int sat_inc(input int v);
        return (v >= 3) ? 3 : v + 1;
    endfunction

    task automatic apply_break(input int i, input int ty);
        case (ty)
            0: begin p_req[i] = 1'b1; p_act[i] = 1'b1; end
            1: begin p_req[i] = 1'b1; p_dbg[i] = 1'b1; end
            default: p_req[i] = 1'b0;
        endcase
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            cg_req       = p_req[i];
            activity     = p_act[i];
            dbg_force_on = p_dbg[i];
            gate_cnt_clr = p_clr[i];
            idle_thresh  = p_thr[i];
            @(posedge clk);
            #1;
        end
    endtask

    // One gate/wake episode. Edge 1 (relative) samples the first request.
    // brk_k > 0 breaks the idle window at its k-th cycle; d >= 1 places the
    // wake break d-1 edges after cg_en first reads 0.
    task automatic run_episode(input int t, input int brk_k, input int brk_ty,
                               input int d, input int wake_ty, input bit clr_gate,
                               input bit scramble);
        int te, g, m, e_end, c, prev, nxt, ed;
        exp_t x;
        te    = (t == 0) ? 1 : t;
        g     = (brk_k == 0) ? 2 + te : (1 + brk_k) + 2 + te;
        m     = g - 1 + d;
        e_end = m + S + 3;
        c     = cyc;
        prev  = model_cnt;
        nxt   = clr_gate ? 0 : sat_inc(prev);
        for (int i = 0; i < e_end; i++) begin
            ed = i + 1;
            p_req[i] = (ed < m);
            p_act[i] = 1'b0;
            p_dbg[i] = 1'b0;
            p_clr[i] = clr_gate && (ed == g - 1 || ed == g);
            p_thr[i] = 8'(t);
            if (brk_k != 0 && ed == 1 + brk_k) apply_break(i, brk_ty);
            if (ed == m) apply_break(i, wake_ty);
            if (ed > m && ed <= m + S) begin
                p_req[i] = 1'($urandom_range(0, 1));
                p_act[i] = 1'($urandom_range(0, 1));
                p_dbg[i] = 1'($urandom_range(0, 1));
            end
            if (scramble && ed > 1 && ed < m) p_thr[i] = 8'($urandom_range(0, 255));
        end
        for (int e = 1; e <= e_end; e++) begin
            x.cyc = c + e;
            x.en  = !(e >= g && e <= m);
            x.gs  = (e >= g && e <= m);
            x.wa  = (e == m + 1 + S);
            if (clr_gate) x.cnt = 2'((e >= g - 1) ? 0 : prev);
            else          x.cnt = 2'((e >= g) ? nxt : prev);
            exp_q.push_back(x);
        end
        model_cnt = nxt;
        drive(e_end);
    endtask

    initial begin
        int t, te, k;
        exp_t x;
        #1 rst_b = 1'b0;
        #2;
        chk("reset_cg_en", cg_en, 1'b1);
        chk("reset_gated_status", gated_status, 1'b0);
        chk("reset_wake_ack", wake_ack, 1'b0);
        chk("reset_gate_cnt", gate_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_b = 1'b1;
        @(posedge clk);
        #1;

        run_episode(16, 0, 0, 3, 0, 1'b0, 1'b0);
        run_episode(4, 3, 0, 2, 0, 1'b0, 1'b0);
        run_episode(0, 0, 0, 1, 1, 1'b0, 1'b0);
        run_episode(5, 5, 1, 2, 2, 1'b0, 1'b0);
        run_episode(3, 0, 0, 4, 0, 1'b1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            t  = $urandom_range(0, 12);
            te = (t == 0) ? 1 : t;
            k  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, te) : 0;
            run_episode(t, k, $urandom_range(0, 2), $urandom_range(1, 5),
                        $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                        (k == 0) && ($urandom_range(0, 1) == 1));
        end

        // Async reset in GATED, between clock edges.
        begin
            int c, g, prev;
            c = cyc;
            g = 4;
            prev = model_cnt;
            for (int i = 0; i <= g; i++) begin
                p_req[i] = 1'b1; p_act[i] = 1'b0; p_dbg[i] = 1'b0;
                p_clr[i] = 1'b0; p_thr[i] = 8'd2;
            end
            for (int e = 1; e <= g + 1; e++) begin
                x.cyc = c + e;
                x.en  = (e < g);
                x.gs  = (e >= g);
                x.wa  = 1'b0;
                x.cnt = 2'((e >= g) ? sat_inc(prev) : prev);
                exp_q.push_back(x);
            end
            drive(g + 1);
            @(negedge clk);
            #2 rst_b = 1'b0;
            #1;
            chk("async_rst_cg_en", cg_en, 1'b1);
            chk("async_rst_gated_status", gated_status, 1'b0);
            chk("async_rst_gate_cnt", gate_cnt, 0);
            model_cnt = 0;
            cg_req = 1'b0;
            @(posedge clk);
            #3 rst_b = 1'b1;
            @(posedge clk);
            #1;
        end

        run_episode(2, 0, 0, 2, 0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            run_episode($urandom_range(0, 6), 0, 0, $urandom_range(1, 5),
                        $urandom_range(0, 2), 1'b0, 1'b1);
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
